// File: rtl/adc_emulator.sv
// Device side of the 8-channel simultaneous-sampling ADC serial link: convst/busy conversion timing plus two MSB-first data lines.
// Optional build macro ADC_EMU_RAMP_EN replaces the sampled inputs with per-channel ramp counters.
module adc_emulator #(
    parameter int W_DATA      = 18,
    parameter int N_CHAN      = 8,
    parameter int CONV_CYCLES = 64
) (
    input  logic                     clk17_in,
    input  logic                     n_reset_in,
    input  logic [N_CHAN*W_DATA-1:0] chan_data_in,
    input  logic [2:0]               adc_os_in,
    input  logic                     adc_convst_in,
    input  logic                     adc_n_cs_in,
    input  logic                     overrun_clr_in,
    output logic                     adc_busy_out,
    output logic                     adc_data_a_out,
    output logic                     adc_data_b_out,
    output logic                     overrun_out,
    output logic                     frame_done_out
);

    localparam int TX_LEN = W_DATA * N_CHAN / 2;
    localparam int CNT_W  = $clog2((CONV_CYCLES << 6) + 1);
    localparam int BIT_W  = $clog2(TX_LEN);
    localparam int VEC_W  = N_CHAN * W_DATA;

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   conv_len;
    logic [2:0]         os_eff;
    logic               convst_q, n_cs_q;
    logic               convst_rise, frame_start;
    logic               load_hold, finish, overrun_set;
    logic [VEC_W-1:0]   sample, hold_q, result_q;
    logic [TX_LEN-1:0]  sh_a_q, sh_b_q;
    logic [BIT_W-1:0]   bit_cnt_q;

    // Link protocol: convst is edge-triggered (0 then 1 across two edges starts a conversion);
    // n_cs is level-framed (1 then 0 loads a frame, each further low edge shifts, high aborts).
    assign convst_rise = adc_convst_in & ~convst_q;
    assign frame_start = ~adc_n_cs_in & n_cs_q;
    assign os_eff      = (adc_os_in > 3'd6) ? 3'd6 : adc_os_in;
    assign conv_len    = CNT_W'(CONV_CYCLES) << os_eff;
    assign overrun_set = convst_rise && (state_q == S_CONV) && (cnt_q != '0);

`ifdef ADC_EMU_RAMP_EN
    logic [W_DATA-1:0] ramp_q [N_CHAN];
    logic              ramp_unused;

    assign ramp_unused = ^chan_data_in;

    always_ff @(posedge clk17_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            for (int c = 0; c < N_CHAN; c++) ramp_q[c] <= W_DATA'(c * 1000);
        end else if (load_hold) begin
            for (int c = 0; c < N_CHAN; c++) ramp_q[c] <= ramp_q[c] + W_DATA'(1);
        end
    end

    always_comb begin
        sample = '0;
        for (int c = 0; c < N_CHAN; c++) sample[(N_CHAN-1-c)*W_DATA +: W_DATA] = ramp_q[c];
    end
`else
    assign sample = chan_data_in;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_hold = 1'b0;
        finish    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (convst_rise) begin
                    state_d   = S_CONV;
                    cnt_d     = conv_len - CNT_W'(1);
                    load_hold = 1'b1;
                end
            end
            S_CONV: begin
                if (cnt_q == '0) begin
                    finish = 1'b1;
                    // A start landing on the final count chains straight into the next conversion.
                    if (convst_rise) begin
                        cnt_d     = conv_len - CNT_W'(1);
                        load_hold = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk17_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            convst_q     <= 1'b0;
            n_cs_q       <= 1'b0;
            hold_q       <= '0;
            result_q     <= '0;
            adc_busy_out <= 1'b0;
            overrun_out  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            convst_q     <= adc_convst_in;
            n_cs_q       <= adc_n_cs_in;
            adc_busy_out <= (state_q == S_CONV);
            if (load_hold) hold_q <= sample;
            if (finish) result_q <= hold_q;
            if (overrun_set) overrun_out <= 1'b1;
            else if (overrun_clr_in) overrun_out <= 1'b0;
        end
    end

    always_ff @(posedge clk17_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            sh_a_q         <= '0;
            sh_b_q         <= '0;
            bit_cnt_q      <= '0;
            frame_done_out <= 1'b0;
        end else if (adc_n_cs_in) begin
            sh_a_q         <= '0;
            sh_b_q         <= '0;
            bit_cnt_q      <= '0;
            frame_done_out <= 1'b0;
        end else if (frame_start) begin
            sh_a_q         <= result_q[VEC_W-1 -: TX_LEN];
            sh_b_q         <= result_q[TX_LEN-1:0];
            bit_cnt_q      <= '0;
            frame_done_out <= 1'b0;
        end else begin
            sh_a_q         <= {sh_a_q[TX_LEN-2:0], 1'b0};
            sh_b_q         <= {sh_b_q[TX_LEN-2:0], 1'b0};
            // Saturate so an over-long frame keeps clocking zeros without a second done pulse.
            if (bit_cnt_q != BIT_W'(TX_LEN - 1)) bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            frame_done_out <= (bit_cnt_q == BIT_W'(TX_LEN - 2));
        end
    end

    assign adc_data_a_out = sh_a_q[TX_LEN-1];
    assign adc_data_b_out = sh_b_q[TX_LEN-1];

endmodule

// File: tb/tb_adc_emulator.sv
// Scoreboarded bench for adc_emulator: stimulus pushes expected busy lengths and frames, a monitor pops and compares.
module tb_adc_emulator;

    localparam int W  = 18;
    localparam int N  = 8;
    localparam int CC = 64;
    localparam int TX = W * N / 2;
    localparam int VW = W * N;

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic [VW-1:0] chan_data = '0;
    logic [2:0]    adc_os = 3'd0;
    logic          convst = 1'b0;
    logic          n_cs = 1'b1;
    logic          ovr_clr = 1'b0;
    logic          busy, data_a, data_b, overrun, frame_done;

    adc_emulator #(.W_DATA(W), .N_CHAN(N), .CONV_CYCLES(CC)) dut (
        .clk17_in(clk), .n_reset_in(n_reset), .chan_data_in(chan_data), .adc_os_in(adc_os),
        .adc_convst_in(convst), .adc_n_cs_in(n_cs), .overrun_clr_in(ovr_clr),
        .adc_busy_out(busy), .adc_data_a_out(data_a), .adc_data_b_out(data_b),
        .overrun_out(overrun), .frame_done_out(frame_done)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    logic [VW-1:0] exp_q[$];
    int            busy_exp_q[$];
    logic [VW-1:0] res_m;
    int            ramp_m[N];

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int conv_len(input int os);
        return CC << ((os > 6) ? 6 : os);
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int c = 0; c < N; c++) v[c*W +: W] = W'($urandom);
        return v;
    endfunction

    function automatic logic [VW-1:0] chan0(input int val);
        logic [VW-1:0] v;
        v = '0;
        v[VW-1 -: W] = W'(val);
        return v;
    endfunction

    // The value a conversion accepted now will eventually report.
    function automatic logic [VW-1:0] capture(input logic [VW-1:0] d);
`ifdef ADC_EMU_RAMP_EN
        logic [VW-1:0] v;
        for (int c = 0; c < N; c++) begin
            v[VW-1-c*W -: W] = W'(ramp_m[c]);
            ramp_m[c] = (ramp_m[c] + 1) % (1 << W);
        end
        return v;
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        res_m = '0;
        for (int c = 0; c < N; c++) ramp_m[c] = c * 1000;
        exp_q.delete();
        busy_exp_q.delete();
    endtask

    // Monitor: rolling window of both lines, busy run-length measurement.
    logic [TX-1:0] win_a = '0;
    logic [TX-1:0] win_b = '0;
    int            run = 0;

    always @(posedge clk) begin
        #1;
        win_a = {win_a[TX-2:0], data_a};
        win_b = {win_b[TX-2:0], data_b};
        if (!n_reset) begin
            run = 0;
        end else begin
            if (busy) begin
                run++;
            end else if (run != 0) begin
                if (busy_exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL busy_len: got unexpected pulse of %0d cycles required none", run);
                end else begin
                    check("busy_len", VW'(run), VW'(busy_exp_q.pop_front()));
                end
                run = 0;
            end
            if (frame_done) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL frame: got unexpected frame_done required none");
                end else begin
                    check("frame", {win_a, win_b}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic pulse_convst();
        @(negedge clk); convst = 1'b1;
        @(negedge clk); convst = 1'b0;
    endtask

    task automatic do_conv(input logic [VW-1:0] d, input int os);
        logic [VW-1:0] cap;
        chan_data = d;
        adc_os = 3'(os);
        pulse_convst();
        cap = capture(d);
        busy_exp_q.push_back(conv_len(os));
        repeat (conv_len(os) + 2) @(negedge clk);
        res_m = cap;
        check("busy_end", VW'(busy), VW'(0));
    endtask

    task automatic read_frame();
        exp_q.push_back(res_m);
        @(negedge clk); n_cs = 1'b0;
        repeat (TX) @(negedge clk);
        n_cs = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        total++; bad++;
        $display("FAIL watchdog: got timeout required completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [VW-1:0] c1, c2;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_busy", VW'(busy), VW'(0));
        check("rst_data_a", VW'(data_a), VW'(0));
        check("rst_data_b", VW'(data_b), VW'(0));
        check("rst_overrun", VW'(overrun), VW'(0));
        check("rst_done", VW'(frame_done), VW'(0));
        n_reset = 1'b1;
        @(negedge clk);
        read_frame();

        // Channel 0 = -22222, everything else zero.
        do_conv(chan0(-22222), 0);
        read_frame();

        for (int i = 0; i < 4; i++) begin
            do_conv(rand_vec(), $urandom_range(0, 2));
            read_frame();
        end
        do_conv(rand_vec(), 3);
        do_conv(rand_vec(), 7);
        read_frame();

        // Ignored start mid-conversion, then clear, then set-with-clear.
        chan_data = rand_vec(); adc_os = 3'd0;
        pulse_convst();
        c1 = capture(chan_data);
        busy_exp_q.push_back(CC);
        repeat (8) @(negedge clk);
        chan_data = rand_vec();
        pulse_convst();
        check("overrun_set", VW'(overrun), VW'(1));
        repeat (CC) @(negedge clk);
        res_m = c1;
        check("busy_end", VW'(busy), VW'(0));
        read_frame();
        ovr_clr = 1'b1; @(negedge clk); ovr_clr = 1'b0;
        check("overrun_clr", VW'(overrun), VW'(0));
        chan_data = rand_vec();
        pulse_convst();
        c1 = capture(chan_data);
        busy_exp_q.push_back(CC);
        repeat (3) @(negedge clk);
        @(negedge clk); convst = 1'b1; ovr_clr = 1'b1;
        @(negedge clk); convst = 1'b0; ovr_clr = 1'b0;
        check("overrun_set_clr", VW'(overrun), VW'(1));
        repeat (CC) @(negedge clk);
        res_m = c1;
        ovr_clr = 1'b1; @(negedge clk); ovr_clr = 1'b0;
        check("overrun_clr2", VW'(overrun), VW'(0));

        // Start on the final count: one continuous busy of two conversion lengths.
        chan_data = rand_vec();
        pulse_convst();
        c1 = capture(chan_data);
        busy_exp_q.push_back(2 * CC);
        repeat (CC - 2) @(negedge clk);
        chan_data = rand_vec();
        pulse_convst();
        c2 = capture(chan_data);
        repeat (CC + 2) @(negedge clk);
        res_m = c2;
        check("b2b_busy_end", VW'(busy), VW'(0));
        check("b2b_overrun", VW'(overrun), VW'(0));
        read_frame();

        // Frame read while the next conversion runs returns the previous result.
        do_conv(chan0(1234), 0);
        chan_data = chan0(5678);
        pulse_convst();
        c2 = capture(chan_data);
        busy_exp_q.push_back(CC);
        read_frame();
        res_m = c2;
        check("rdconv_busy_end", VW'(busy), VW'(0));
        read_frame();

        // Abort after 20 bits, then a full fresh frame.
        do_conv({VW{1'b1}}, 0);
        @(negedge clk); n_cs = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_pre", VW'(data_a), VW'(res_m[VW-1-19]));
        n_cs = 1'b1;
        @(negedge clk);
        check("abort_a", VW'(data_a), VW'(0));
        check("abort_b", VW'(data_b), VW'(0));
        read_frame();

        // Asynchronous reset during a conversion and a frame.
        chan_data = rand_vec();
        pulse_convst();
        c1 = capture(chan_data);
        busy_exp_q.push_back(CC);
        repeat (8) @(negedge clk);
        pulse_convst();
        @(negedge clk); n_cs = 1'b0;
        repeat (10) @(negedge clk);
        n_reset = 1'b0;
        #1;
        check("midrst_busy", VW'(busy), VW'(0));
        check("midrst_data_a", VW'(data_a), VW'(0));
        check("midrst_data_b", VW'(data_b), VW'(0));
        check("midrst_overrun", VW'(overrun), VW'(0));
        model_reset();
        n_cs = 1'b1;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        read_frame();
        do_conv(rand_vec(), 0);
        read_frame();
        do_conv(rand_vec(), 0);
        read_frame();

        repeat (5) @(negedge clk);
        check("frames_left", VW'(exp_q.size()), VW'(0));
        check("busy_left", VW'(busy_exp_q.size()), VW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
